// File: rtl/scroller_pkg.sv
// rtl/scroller_pkg.sv - shared VGA timing, scheduler state encoding and cell-width helper
package scroller_pkg;

   localparam int H_TOTAL      = 800;
   localparam int V_TOTAL      = 525;
   localparam int H_VIS        = 640;
   localparam int V_VIS        = 480;
   localparam int LINE_START_X = 656;
   localparam int FRAME_LINE   = 482;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_STEP = 2'd2,
      S_NEXT = 2'd3
   } sched_state_e;

   // log2 of the cell width of layer l; nearer layers have wider cells, far layers bottom out at 1 pixel
   function automatic int cell_log2(input int l, input int max_log2);
      return (max_log2 > l) ? (max_log2 - l) : 0;
   endfunction

endpackage

// File: rtl/scroll_cell_counter.sv
// rtl/scroll_cell_counter.sv - per-layer cell position counter and fine scroll offset
module scroll_cell_counter #(
   parameter int W  = 3,
   parameter int CW = 3
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       reload_i,
   input  logic       advance_i,
   input  logic       update_i,
   input  logic [1:0] speed_i,
   output logic       cnt_zero_o,
   output logic [1:0] steps_o
);

   // one extra bit holds the carry out of fine+speed, which is the base-LFSR step count
   localparam int           SUM_W = (W >= 2) ? W + 1 : 3;
   localparam logic [W-1:0] MASK  = W'((1 << CW) - 1);

   logic [W-1:0]     cell_cnt_q, cell_cnt_d;
   logic [W-1:0]     fine_q, fine_d;
   logic [SUM_W-1:0] sum;

   assign sum        = SUM_W'(fine_q) + SUM_W'(speed_i);
   assign steps_o    = 2'(sum >> CW);
   assign cnt_zero_o = (cell_cnt_q == '0);

   // line reload wins over pixel advance; fine only moves in this layer's frame-update slot
   always_comb begin
      cell_cnt_d = cell_cnt_q;
      fine_d     = fine_q;
      if (reload_i) begin
         cell_cnt_d = fine_q;
      end else if (advance_i) begin
         cell_cnt_d = (cell_cnt_q + W'(1)) & MASK;
      end
      if (update_i) begin
         fine_d = sum[W-1:0] & MASK;
      end
   end

   // counter and fine offset registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cell_cnt_q <= '0;
         fine_q     <= '0;
      end else begin
         cell_cnt_q <= cell_cnt_d;
         fine_q     <= fine_d;
      end
   end

endmodule

// File: rtl/parallax_scroll_sched.sv
// rtl/parallax_scroll_sched.sv - per-pixel, per-line and per-frame timing for the parallax LFSR layers
module parallax_scroll_sched
   import scroller_pkg::*;
#(
   parameter int NUM_LAYERS    = 4,
   parameter int CELL_LOG2_MAX = 3,
   parameter int LINE_START_X  = 656,
   parameter int FRAME_LINE    = 482
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [9:0]              hcount,
   input  logic [9:0]              vcount,
   input  logic                    visible,
   input  logic [2*NUM_LAYERS-1:0] speed_cfg,
   input  logic                    pause,
   output logic [NUM_LAYERS-1:0]   layer_line_load,
   output logic [NUM_LAYERS-1:0]   layer_pix_step,
   output logic [NUM_LAYERS-1:0]   layer_base_step,
   output logic                    busy
);

   localparam int IDX_W = (NUM_LAYERS > 1) ? $clog2(NUM_LAYERS) : 1;

   sched_state_e            state_q, state_d;
   logic [IDX_W-1:0]        idx_q, idx_d;
   logic [1:0]              steps_q, steps_d;
   logic [2*NUM_LAYERS-1:0] spd_q, spd_d;
   logic                    line_load_q;
   logic                    line_hit, frame_hit;
   logic [NUM_LAYERS-1:0]   cnt_zero;
   logic [1:0]              layer_steps [NUM_LAYERS];
   logic [1:0]              sel_steps;

   assign line_hit  = (hcount == 10'(LINE_START_X));
   assign frame_hit = line_hit && (vcount == 10'(FRAME_LINE)) && !pause;
   assign sel_steps = layer_steps[idx_q];

   for (genvar l = 0; l < NUM_LAYERS; l++) begin : g_layer
      scroll_cell_counter #(
         .W (CELL_LOG2_MAX),
         .CW(cell_log2(l, CELL_LOG2_MAX))
      ) u_cnt (
         .clk       (clk),
         .rst_n     (rst_n),
         .reload_i  (line_hit),
         .advance_i (visible),
         .update_i  ((state_q == S_CALC) && (idx_q == IDX_W'(l))),
         .speed_i   (spd_q[2*l +: 2]),
         .cnt_zero_o(cnt_zero[l]),
         .steps_o   (layer_steps[l])
      );
   end

   assign layer_line_load = {NUM_LAYERS{line_load_q}};
   assign layer_pix_step  = cnt_zero & {NUM_LAYERS{visible}};
   assign busy            = (state_q != S_IDLE);

   // frame update walker: one layer at a time, CALC then its base steps then NEXT
   always_comb begin
      state_d         = state_q;
      idx_d           = idx_q;
      steps_d         = steps_q;
      spd_d           = spd_q;
      layer_base_step = '0;
      unique case (state_q)
         S_IDLE: begin
            if (frame_hit) begin
               spd_d   = speed_cfg;
               idx_d   = '0;
               state_d = S_CALC;
            end
         end
         S_CALC: begin
            steps_d = sel_steps;
            state_d = (sel_steps != 2'd0) ? S_STEP : S_NEXT;
         end
         S_STEP: begin
            layer_base_step = NUM_LAYERS'(1) << idx_q;
            steps_d         = steps_q - 2'd1;
            if (steps_q == 2'd1) begin
               state_d = S_NEXT;
            end
         end
         S_NEXT: begin
            if (idx_q == IDX_W'(NUM_LAYERS - 1)) begin
               state_d = S_IDLE;
            end else begin
               idx_d   = idx_q + IDX_W'(1);
               state_d = S_CALC;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   // scheduler state, speed snapshot and the delayed line-load strobe
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         idx_q       <= '0;
         steps_q     <= '0;
         spd_q       <= '0;
         line_load_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         steps_q     <= steps_d;
         spd_q       <= spd_d;
         line_load_q <= line_hit;
      end
   end

endmodule
